// File: rtl/run_detect_pkg.sv
// Shared types and helpers for the run-length detector scheduler.
// RUN_DETECT_EARLY_EXIT_EN (optional) ends a window on its first hit.
package run_detect_pkg;

  localparam int LANES_DEF  = 4;
  localparam int WINDOW_DEF = 16;
  localparam int CNT_W_DEF  = 5;
  localparam int THRESH_DEF = 4;
  localparam int LANE_W_DEF = $clog2(LANES_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  // First set bit at index >= ptr, wrapping modulo n
  function automatic int rr_pick(
    input logic [31:0] req,
    input int          ptr,
    input int          n
  );
    rr_pick = ptr;
    for (int i = 31; i >= 0; i--) begin
      if (i < n && req[(ptr + i) % n]) begin
        rr_pick = (ptr + i) % n;
      end
    end
  endfunction

endpackage

// File: rtl/run_detect_sched_rr_arbiter.sv
// Combinational round-robin pick over the lane requests.
// Used by run_detect_sched (see RUN_DETECT_EARLY_EXIT_EN there).
module rr_arbiter
  import run_detect_pkg::*;
#(
  parameter int N = LANES_DEF,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         any_req
);

  always_comb begin
    sel     = W'(rr_pick(32'(req), int'(ptr), N));
    any_req = |req;
  end

endmodule

// File: rtl/run_detect_sched.sv
// Shared consecutive-ones run detector, time-multiplexed over lanes.
// Define RUN_DETECT_EARLY_EXIT_EN to report as soon as a hit is seen.
module run_detect_sched
  import run_detect_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int WINDOW     = WINDOW_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEF_THRESH = THRESH_DEF,
  localparam int LW        = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] ain,
  input  logic [LANES-1:0] req,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic [LANES-1:0] gnt,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    done_lane,
  output logic             hit
);

`ifdef RUN_DETECT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [LW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic             hit_q, hit_d;
  logic [LANES-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LW-1:0]    done_lane_q, done_lane_d;
  logic             hit_out_q, hit_out_d;

  logic [LW-1:0]    sel;
  logic             any_req;
  logic [CNT_W:0]   run_inc;
  logic [LW-1:0]    lane_nxt;
  logic             bit_s;
  logic             hit_set;
  logic             last;

  rr_arbiter #(
    .N (LANES),
    .W (LW)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .sel     (sel),
    .any_req (any_req)
  );

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    rr_ptr_d    = rr_ptr_q;
    run_cnt_d   = run_cnt_q;
    win_cnt_d   = win_cnt_q;
    thresh_d    = thresh_q;
    hit_d       = hit_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    done_lane_d = done_lane_q;
    hit_out_d   = 1'b0;

    run_inc  = {1'b0, run_cnt_q} + (CNT_W+1)'(1);
    bit_s    = ain[lane_q];
    hit_set  = bit_s && (run_inc >= {1'b0, thresh_q});
    last     = (win_cnt_q == CNT_W'(WINDOW - 1));
    lane_nxt = (lane_q == LW'(LANES - 1)) ? '0
                                          : lane_q + LW'(1);

    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (cfg_load) begin
          thresh_d = (cfg_thresh == '0) ? CNT_W'(1)
                                        : cfg_thresh;
        end
        if (any_req) begin
          state_d   = ST_RUN;
          lane_d    = sel;
          gnt_d     = LANES'(1) << sel;
          busy_d    = 1'b1;
          run_cnt_d = '0;
          win_cnt_d = '0;
          hit_d     = 1'b0;
        end
      end
      state_q == ST_RUN: begin
        if (!req[lane_q]) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          busy_d   = 1'b0;
          rr_ptr_d = lane_nxt;
        end else begin
          if (!bit_s) begin
            run_cnt_d = '0;
          end else if (!(&run_cnt_q)) begin
            run_cnt_d = run_inc[CNT_W-1:0];
          end
          hit_d     = hit_q | hit_set;
          win_cnt_d = win_cnt_q + CNT_W'(1);
          if (last || (EARLY && hit_set)) begin
            state_d     = ST_REPORT;
            gnt_d       = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            hit_out_d   = hit_q | hit_set;
            done_lane_d = lane_q;
          end
        end
      end
      state_q == ST_REPORT: begin
        rr_ptr_d = lane_nxt;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      rr_ptr_q    <= '0;
      run_cnt_q   <= '0;
      win_cnt_q   <= '0;
      thresh_q    <= CNT_W'(DEF_THRESH);
      hit_q       <= 1'b0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_lane_q <= '0;
      hit_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      rr_ptr_q    <= rr_ptr_d;
      run_cnt_q   <= run_cnt_d;
      win_cnt_q   <= win_cnt_d;
      thresh_q    <= thresh_d;
      hit_q       <= hit_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_lane_q <= done_lane_d;
      hit_out_q   <= hit_out_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_lane = done_lane_q;
  assign hit       = hit_out_q;

endmodule

// File: doc/run_detect_sched.md
Name: run_detect_sched

Overview:
- Shares one consecutive-ones run-length detector engine among LANES serial input lanes.
- Round-robin arbitration grants one requesting lane at a time.
- The engine samples the granted lane's serial bit for a fixed window and reports whether a run of at least `thresh` consecutive 1s occurred.
- Sits between the serial lane sources and the downstream event logic; replaces per-lane fixed 4-ones detectors.

Parameters:
- LANES, 4, number of serial requesters.
- WINDOW, 16, number of samples taken per grant.
- CNT_W, 5, width of the run/window counters; must satisfy 2^CNT_W > WINDOW.
- DEF_THRESH, 4, threshold value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ain  in  LANES  serial data, one bit per lane.
- req  in  LANES  per-lane request, level; held high until done or abandon.
- cfg_load  in  1  load cfg_thresh into the threshold register.
- cfg_thresh  in  CNT_W  new run-length threshold.
- gnt  out  LANES  one-hot grant, registered.
- busy  out  1  high in RUN.
- done  out  1  one-cycle result strobe.
- done_lane  out  $clog2(LANES)  lane the result belongs to; valid with done.
- hit  out  1  run of at least thresh seen; valid with done.

Behaviour:
- Reset (reset==0, asynchronous):
  - State IDLE; gnt=0, busy=0, done=0, hit=0, done_lane=0.
  - rr_ptr=0, run_cnt=0, win_cnt=0, thresh_q=DEF_THRESH.
- Threshold load:
  - cfg_load is honoured only in IDLE; it is ignored in RUN and REPORT.
  - cfg_thresh==0 loads 1.
  - A threshold greater than WINDOW is legal and can never hit.
  - If cfg_load and a req are seen in the same IDLE cycle, the new threshold applies to that grant.
- States: IDLE, RUN, REPORT.
- IDLE:
  - If req!=0, select the first set req bit at index ≥ rr_ptr, wrapping modulo LANES.
  - At that edge: gnt=onehot(sel), lane_q=sel, busy=1, run_cnt=0, win_cnt=0, hit_q=0; go to RUN.
- RUN: each edge samples b=ain[lane_q].
  - If b=1: run_cnt=run_cnt+1, saturating at 2^CNT_W-1. If run_cnt+1 ≥ thresh_q, set hit_q (sticky).
  - If b=0: run_cnt=0.
  - win_cnt increments each edge; the sample taken while win_cnt==WINDOW-1 is the last one, and that edge moves to REPORT.
  - Runs overlap: 6 consecutive 1s with thresh 4 is still one hit.
- Timing: RUN entered at edge k; samples at edges k+1..k+WINDOW; done high during the cycle after edge k+WINDOW.
- Abandon:
  - If req[lane_q] drops in RUN: go to IDLE at the next edge.
  - gnt=0, busy=0, no done; rr_ptr=lane_q+1 mod LANES.
- REPORT (one cycle):
  - done=1, hit=hit_q, done_lane=lane_q; gnt=0, busy=0.
  - At the exit edge: rr_ptr=lane_q+1 mod LANES; go to IDLE.
- Fairness: a lane still requesting after done is re-arbitrated in IDLE behind the other requesters. Minimum spacing between grants is one IDLE cycle.
- Mid-operation reset: everything returns to reset values immediately; no done is issued.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: RUN_DETECT_EARLY_EXIT_EN.
- Defined: the edge that sets hit_q moves RUN→REPORT immediately. done follows the hit-setting sample by one cycle; a window with no hit still runs its full WINDOW samples.
- Undefined: the full WINDOW is always sampled.

Decomposition:
- Package run_detect_pkg:
  - State enum (IDLE/RUN/REPORT).
  - Default LANES/WINDOW/CNT_W/DEF_THRESH constants.
  - Lane-index width constant.
  - Function for wrap-around rotate-priority select.
- Sub-module rr_arbiter: combinational round-robin pick from req and rr_ptr; outputs sel and any_req.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req=4'b0001 → gnt=0, busy=0, done=0, hit=0. Release, then req sampled → gnt=4'b0001 after the next edge.
- Threshold 4, lane 0: ain[0]=1 for 6 samples then 0 → done one cycle after the 16th sample, done_lane=0, hit=1; gnt drops with done.
- Threshold 4, lane 2: sample stream 1,0,1,1,1,0,1,1,1,0… (max run 3) → done_lane=2, hit=0.
- Round-robin: req=4'b1111 held, all ain=0 → grant order 0,1,2,3,0, one IDLE cycle between each done and the next gnt.
- Threshold handling:
  - cfg_load with cfg_thresh=0 in IDLE, single 1 on lane 1 → hit=1.
  - cfg_load with cfg_thresh=7 during RUN is ignored; the next grant still uses threshold 1.
- Abandon and reset:
  - Drop req[3] at sample 5 → no done, next grant goes to lane 0.
  - reset=0 at sample 8 of a window → immediate idle, no done.
  - With RUN_DETECT_EARLY_EXIT_EN defined, 4 ones at samples 1-4 → done one cycle after sample 4.
